// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller: FSM state
// encodings, counter widths, the memory-wait timeout threshold and the
// bundle of stage-control signals the controller drives.
package mips_pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_FLUSH      = 2'd2,
      ST_MEM_WAIT   = 2'd3
   } hazard_state_e;

   localparam int STALL_CNT_W = 16;
   localparam int WAIT_CNT_W  = 8;

   // Consecutive MEM_WAIT cycles after which the memory is considered hung.
   localparam logic [WAIT_CNT_W-1:0] MEM_TIMEOUT = 8'd255;

   // One bit per pipeline control line; writes are 1 = advance,
   // flushes/bubble are 1 = zero the control bits of that buffer.
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic idex_write;
      logic exmem_write;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_bubble;
      logic pc_src;
   } hazard_ctrl_t;

   // Control word for a pipeline that simply advances with no hazard.
   function automatic hazard_ctrl_t ctrl_advance();
      hazard_ctrl_t c;
      c              = '0;
      c.pc_write     = 1'b1;
      c.ifid_write   = 1'b1;
      c.idex_write   = 1'b1;
      c.exmem_write  = 1'b1;
      return c;
   endfunction

   // True when a load writing dst feeds either source of the next
   // instruction; $zero is never a real dependency.
   function automatic logic reg_hazard(input logic [4:0] dst,
                                       input logic [4:0] src_a,
                                       input logic [4:0] src_b);
      return (dst != 5'd0) && ((dst == src_a) || (dst == src_b));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Parameterised-width up counter that sticks at its maximum value instead
// of wrapping, with a synchronous clear and a synchronous active-low reset.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   // Count up on enable, hold at all-ones, clear takes priority over enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS pipeline. Decodes memory-wait,
// branch/jump redirect and load-use hazards into stage enables, flushes and
// a PC-source select, tracks the controller state, and keeps stall and
// memory-wait statistics including a sticky memory timeout flag.
module pipeline_hazard_ctrl
   import mips_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic [4:0]  i_ifid_rs,
   input  logic [4:0]  i_ifid_rt,
   input  logic        i_idex_memRead,
   input  logic [4:0]  i_idex_rt,
   input  logic        i_exmem_branch,
   input  logic        i_exmem_zf,
   input  logic        i_exmem_jump,
   input  logic        i_exmem_memRead,
   input  logic        i_exmem_memWrite,
   input  logic        i_mem_ready,
   output logic        o_pc_write,
   output logic        o_ifid_write,
   output logic        o_idex_write,
   output logic        o_exmem_write,
   output logic        o_ifid_flush,
   output logic        o_idex_flush,
   output logic        o_exmem_flush,
   output logic        o_memwb_bubble,
   output logic        o_pc_src,
   output logic [1:0]  o_state,
   output logic [15:0] o_stall_count,
   output logic        o_mem_timeout
);

   hazard_state_e           state;
   hazard_state_e           next_state;
   hazard_ctrl_t            ctrl;
   logic                    redirect;
   logic                    redirect_pending;
   logic                    redirect_eff;
   logic                    memwait;
   logic                    loaduse;
   logic                    mem_timeout;
   logic [WAIT_CNT_W-1:0]   wait_count;
   logic [STALL_CNT_W-1:0]  stall_count;

   // Raw hazard conditions seen this cycle; a redirect that arrived during a
   // memory wait is remembered so it cannot be lost when the wait ends.
   always_comb begin
      redirect     = (i_exmem_branch & i_exmem_zf) | i_exmem_jump;
      memwait      = (i_exmem_memRead | i_exmem_memWrite) & ~i_mem_ready;
      loaduse      = i_idex_memRead & reg_hazard(i_idex_rt, i_ifid_rs, i_ifid_rt);
      redirect_eff = redirect | redirect_pending;
   end

   // Priority decode (memwait > redirect > loaduse) of this cycle's controls
   // and the state to enter on the next edge; reset forces a free-running pipe.
   always_comb begin
      ctrl       = ctrl_advance();
      next_state = ST_RUN;
      if (!i_rst_n) begin
         ctrl       = ctrl_advance();
         next_state = ST_RUN;
      end else if (memwait) begin
         ctrl              = '0;
         ctrl.memwb_bubble = 1'b1;
         next_state        = ST_MEM_WAIT;
      end else if (redirect_eff) begin
         ctrl.pc_src      = 1'b1;
         ctrl.ifid_flush  = 1'b1;
         ctrl.idex_flush  = 1'b1;
         ctrl.exmem_flush = 1'b1;
         next_state       = ST_FLUSH;
      end else if (loaduse && (state != ST_LOAD_STALL)) begin
         ctrl.pc_write   = 1'b0;
         ctrl.ifid_write = 1'b0;
         ctrl.idex_flush = 1'b1;
         next_state      = ST_LOAD_STALL;
      end
   end

   // State register plus the deferred-redirect flag, both dropped on reset.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state            <= ST_RUN;
         redirect_pending <= 1'b0;
      end else begin
         state            <= next_state;
         redirect_pending <= memwait & redirect_eff;
      end
   end

   // Sticky timeout: once the memory has been waited on for the limit, keep
   // reporting it until reset even though stalling continues.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         mem_timeout <= 1'b0;
      end else if (wait_count == MEM_TIMEOUT) begin
         mem_timeout <= 1'b1;
      end
   end

   sat_counter #(
      .WIDTH (STALL_CNT_W)
   ) u_stall_counter (
      .clk    (clk),
      .rst_n  (i_rst_n),
      .clear  (1'b0),
      .enable (~ctrl.pc_write),
      .count  (stall_count)
   );

   sat_counter #(
      .WIDTH (WAIT_CNT_W)
   ) u_wait_counter (
      .clk    (clk),
      .rst_n  (i_rst_n),
      .clear  (~memwait),
      .enable (memwait),
      .count  (wait_count)
   );

   assign o_pc_write     = ctrl.pc_write;
   assign o_ifid_write   = ctrl.ifid_write;
   assign o_idex_write   = ctrl.idex_write;
   assign o_exmem_write  = ctrl.exmem_write;
   assign o_ifid_flush   = ctrl.ifid_flush;
   assign o_idex_flush   = ctrl.idex_flush;
   assign o_exmem_flush  = ctrl.exmem_flush;
   assign o_memwb_bubble = ctrl.memwb_bubble;
   assign o_pc_src       = ctrl.pc_src;
   assign o_state        = state;
   assign o_stall_count  = stall_count;
   assign o_mem_timeout  = mem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, self-checking bench for pipeline_hazard_ctrl. Each step drives
// inputs just after a rising edge, queues the expected controls/state/
// counters, and compares them on the following falling edge.
module tb_pipeline_hazard_ctrl;

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_LDST = 2'd1;
   localparam logic [1:0] S_FLSH = 2'd2;
   localparam logic [1:0] S_MWT  = 2'd3;

   // {pc_w, ifid_w, idex_w, exmem_w, ifid_fl, idex_fl, exmem_fl, bubble, pc_src}
   localparam logic [8:0] C_IDLE  = 9'b1111_0000_0;
   localparam logic [8:0] C_MEMW  = 9'b0000_0001_0;
   localparam logic [8:0] C_REDIR = 9'b1111_1110_1;
   localparam logic [8:0] C_LDUSE = 9'b0011_0100_0;

   typedef struct {
      string       tag;
      logic [8:0]  ctrl;
      logic [1:0]  state;
      logic [15:0] stall;
      logic        tmo;
   } exp_t;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic [4:0]  i_ifid_rs;
   logic [4:0]  i_ifid_rt;
   logic        i_idex_memRead;
   logic [4:0]  i_idex_rt;
   logic        i_exmem_branch;
   logic        i_exmem_zf;
   logic        i_exmem_jump;
   logic        i_exmem_memRead;
   logic        i_exmem_memWrite;
   logic        i_mem_ready;
   logic        o_pc_write;
   logic        o_ifid_write;
   logic        o_idex_write;
   logic        o_exmem_write;
   logic        o_ifid_flush;
   logic        o_idex_flush;
   logic        o_exmem_flush;
   logic        o_memwb_bubble;
   logic        o_pc_src;
   logic [1:0]  o_state;
   logic [15:0] o_stall_count;
   logic        o_mem_timeout;
   logic [8:0]  dut_ctrl;

   exp_t        sb[$];
   int          n_vectors = 0;
   int          n_miscompares = 0;
   logic [15:0] model_stall = 16'd0;
   logic [8:0]  last_ctrl;

   pipeline_hazard_ctrl dut (
      .clk              (clk),
      .i_rst_n          (i_rst_n),
      .i_ifid_rs        (i_ifid_rs),
      .i_ifid_rt        (i_ifid_rt),
      .i_idex_memRead   (i_idex_memRead),
      .i_idex_rt        (i_idex_rt),
      .i_exmem_branch   (i_exmem_branch),
      .i_exmem_zf       (i_exmem_zf),
      .i_exmem_jump     (i_exmem_jump),
      .i_exmem_memRead  (i_exmem_memRead),
      .i_exmem_memWrite (i_exmem_memWrite),
      .i_mem_ready      (i_mem_ready),
      .o_pc_write       (o_pc_write),
      .o_ifid_write     (o_ifid_write),
      .o_idex_write     (o_idex_write),
      .o_exmem_write    (o_exmem_write),
      .o_ifid_flush     (o_ifid_flush),
      .o_idex_flush     (o_idex_flush),
      .o_exmem_flush    (o_exmem_flush),
      .o_memwb_bubble   (o_memwb_bubble),
      .o_pc_src         (o_pc_src),
      .o_state          (o_state),
      .o_stall_count    (o_stall_count),
      .o_mem_timeout    (o_mem_timeout)
   );

   assign dut_ctrl = {o_pc_write, o_ifid_write, o_idex_write, o_exmem_write,
                      o_ifid_flush, o_idex_flush, o_exmem_flush,
                      o_memwb_bubble, o_pc_src};

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Put every hazard input into its quiet value (reset left untouched).
   task automatic neutral();
      i_ifid_rs        = 5'd1;
      i_ifid_rt        = 5'd2;
      i_idex_memRead   = 1'b0;
      i_idex_rt        = 5'd3;
      i_exmem_branch   = 1'b0;
      i_exmem_zf       = 1'b0;
      i_exmem_jump     = 1'b0;
      i_exmem_memRead  = 1'b0;
      i_exmem_memWrite = 1'b0;
      i_mem_ready      = 1'b1;
   endtask

   // Queue the expected response to the inputs currently being driven.
   task automatic applyStimulus(input string tag, input logic [8:0] ec,
                                input logic [1:0] es, input logic et);
      exp_t e;
      e.tag   = tag;
      e.ctrl  = ec;
      e.state = es;
      e.stall = model_stall;
      e.tmo   = et;
      sb.push_back(e);
      last_ctrl = ec;
   endtask

   // On the falling edge, pop the oldest expectation and compare all outputs.
   task automatic checkOutput();
      exp_t e;
      @(negedge clk);
      n_vectors++;
      assert (sb.size() != 0)
         else begin
            n_miscompares++;
            $error("[TB] FAIL scoreboard empty observed=0 expected=1 entry");
         end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_vectors++;
         assert (dut_ctrl === e.ctrl)
            else begin
               n_miscompares++;
               $error("[TB] FAIL %s ctrl observed=%b expected=%b", e.tag, dut_ctrl, e.ctrl);
            end
         n_vectors++;
         assert (o_state === e.state)
            else begin
               n_miscompares++;
               $error("[TB] FAIL %s state observed=%0d expected=%0d", e.tag, o_state, e.state);
            end
         n_vectors++;
         assert (o_stall_count === e.stall)
            else begin
               n_miscompares++;
               $error("[TB] FAIL %s stall_count observed=%0d expected=%0d", e.tag, o_stall_count, e.stall);
            end
         n_vectors++;
         assert (o_mem_timeout === e.tmo)
            else begin
               n_miscompares++;
               $error("[TB] FAIL %s mem_timeout observed=%b expected=%b", e.tag, o_mem_timeout, e.tmo);
            end
      end
   endtask

   // One full cycle: queue, check, cross the edge, then advance the stall model.
   task automatic step(input string tag, input logic [8:0] ec,
                       input logic [1:0] es, input logic et);
      applyStimulus(tag, ec, es, et);
      checkOutput();
      @(posedge clk);
      if (!i_rst_n)
         model_stall = 16'd0;
      else if (!last_ctrl[8] && (model_stall != 16'hFFFF))
         model_stall = model_stall + 16'd1;
      #1;
   endtask

   initial begin
      i_rst_n = 1'b0;
      neutral();
      @(posedge clk);
      #1;

      // Reset held with every hazard asserted: pipeline must run free.
      i_exmem_memRead = 1'b1; i_mem_ready = 1'b0;
      i_exmem_branch = 1'b1; i_exmem_zf = 1'b1;
      i_idex_memRead = 1'b1; i_idex_rt = 5'd8; i_ifid_rs = 5'd8;
      step("reset_hold", C_IDLE, S_RUN, 1'b0);
      i_rst_n = 1'b1;
      neutral();
      step("idle", C_IDLE, S_RUN, 1'b0);

      // Load-use on rs, LOAD_STALL ignores the still-present hazard.
      i_idex_memRead = 1'b1; i_idex_rt = 5'd8; i_ifid_rs = 5'd8;
      step("loaduse_rs", C_LDUSE, S_RUN, 1'b0);
      step("ldstall_hold", C_IDLE, S_LDST, 1'b0);
      neutral();
      step("ldstall_exit", C_IDLE, S_RUN, 1'b0);

      // $zero destination never stalls.
      i_idex_memRead = 1'b1; i_idex_rt = 5'd0; i_ifid_rs = 5'd0; i_ifid_rt = 5'd0;
      step("zero_reg", C_IDLE, S_RUN, 1'b0);
      step("zero_reg_next", C_IDLE, S_RUN, 1'b0);

      // Load-use through rt, then non-load matching registers.
      neutral();
      i_idex_memRead = 1'b1; i_idex_rt = 5'd5; i_ifid_rs = 5'd3; i_ifid_rt = 5'd5;
      step("loaduse_rt", C_LDUSE, S_RUN, 1'b0);
      neutral();
      step("ldrt_stall", C_IDLE, S_LDST, 1'b0);
      i_idex_memRead = 1'b0; i_idex_rt = 5'd8; i_ifid_rs = 5'd8;
      step("no_load_match", C_IDLE, S_RUN, 1'b0);

      // Taken branch, FLUSH for one cycle, then a not-taken branch.
      neutral();
      i_exmem_branch = 1'b1; i_exmem_zf = 1'b1;
      step("branch_taken", C_REDIR, S_RUN, 1'b0);
      neutral();
      step("flush_state", C_IDLE, S_FLSH, 1'b0);
      i_exmem_branch = 1'b1; i_exmem_zf = 1'b0;
      step("branch_not_taken", C_IDLE, S_RUN, 1'b0);

      // Jump, then load-use arriving while in FLUSH.
      neutral();
      i_exmem_jump = 1'b1;
      step("jump", C_REDIR, S_RUN, 1'b0);
      neutral();
      i_idex_memRead = 1'b1; i_idex_rt = 5'd8; i_ifid_rs = 5'd8;
      step("flush_loaduse", C_LDUSE, S_FLSH, 1'b0);
      neutral();
      step("flush_ld_stall", C_IDLE, S_LDST, 1'b0);

      // Three-cycle memory read wait.
      i_exmem_memRead = 1'b1; i_mem_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         step("memwait_rd", C_MEMW, (i == 0) ? S_RUN : S_MWT, 1'b0);
      i_mem_ready = 1'b1;
      step("memwait_ready", C_IDLE, S_MWT, 1'b0);
      neutral();
      step("memwait_after", C_IDLE, S_RUN, 1'b0);

      // Memory write wait.
      i_exmem_memWrite = 1'b1; i_mem_ready = 1'b0;
      step("memwait_wr", C_MEMW, S_RUN, 1'b0);
      i_mem_ready = 1'b1;
      step("memwait_wr_ready", C_IDLE, S_MWT, 1'b0);

      // memwait + redirect + loaduse: wait first, redirect wins on ready.
      neutral();
      i_exmem_memRead = 1'b1; i_mem_ready = 1'b0;
      i_exmem_branch = 1'b1; i_exmem_zf = 1'b1;
      i_idex_memRead = 1'b1; i_idex_rt = 5'd8; i_ifid_rs = 5'd8;
      step("simul_wait0", C_MEMW, S_RUN, 1'b0);
      step("simul_wait1", C_MEMW, S_MWT, 1'b0);
      i_mem_ready = 1'b1;
      step("simul_ready", C_REDIR, S_MWT, 1'b0);
      i_exmem_branch = 1'b0; i_exmem_zf = 1'b0; i_exmem_memRead = 1'b0;
      step("simul_flush_ld", C_LDUSE, S_FLSH, 1'b0);
      neutral();
      step("simul_ldstall", C_IDLE, S_LDST, 1'b0);

      // Long memory wait: timeout appears after the 256th waiting edge.
      i_exmem_memRead = 1'b1; i_mem_ready = 1'b0;
      for (int i = 0; i < 258; i++)
         step("timeout_wait", C_MEMW, (i == 0) ? S_RUN : S_MWT, (i >= 256) ? 1'b1 : 1'b0);

      // Reset mid-wait abandons the stall and clears everything.
      i_rst_n = 1'b0;
      step("reset_mid_wait", C_IDLE, S_MWT, 1'b1);
      i_rst_n = 1'b1;
      neutral();
      step("after_reset", C_IDLE, S_RUN, 1'b0);
      i_idex_memRead = 1'b1; i_idex_rt = 5'd8; i_ifid_rs = 5'd8;
      step("after_reset_ld", C_LDUSE, S_RUN, 1'b0);
      neutral();
      step("after_reset_ldst", C_IDLE, S_LDST, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
